ixc_sample_fifo: RTL and testbench
==================================

Name: ixc_sample_fifo

Overview:
Parametrised, clocked successor to the single-bit sample latch. Captures a WIDTH-bit value vector whenever the emulator sample condition fires (`sample_ov` or `call_emu_pre`). Each capture updates the held sample output and pushes a timestamped record into a DEPTH-entry FIFO, which the host drains over a valid/ready handshake. Optional change-only mode suppresses duplicate captures. Sits beside xc_top sampling logic, always-on domain.

Parameters:
WIDTH, 1, number of sampled value bits
DEPTH, 4, FIFO entries; power of 2, minimum 2
TSW, 16, timestamp counter width
CHANGE_ONLY, 0, 1 = capture only when v differs from sv (first request after reset always captures)

Ports:
clk  input  1  sampling clock
rst  input  1  synchronous reset, active-high
v  input  WIDTH  value to sample
sample_ov  input  1  sample override request
call_emu_pre  input  1  emulator pre-call sample request
sv  output  WIDTH  most recently captured value
rd_valid  output  1  FIFO not empty; rd_data valid
rd_ready  input  1  host accepts head entry
rd_data  output  TSW+WIDTH  head record: {timestamp, value}
level  output  clog2(DEPTH+1)  current FIFO occupancy
overflow  output  1  sticky: a capture was dropped because the FIFO was full
clr_ovf  input  1  clears overflow

Behaviour:
- Reset (rst=1 at a clk edge): sv=0, FIFO empty, rd_valid=0, level=0, overflow=0, timestamp=0, change-mode primed flag cleared. rst has priority over every other input; mid-operation reset discards all FIFO contents.
- Timestamp: free-running TSW-bit counter; +1 every non-reset cycle; wraps from all-ones to 0.
- req = sample_ov | call_emu_pre, evaluated each cycle.
- cap = req when CHANGE_ONLY=0. When CHANGE_ONLY=1: cap = req & (!primed | v != sv). primed is set on the first cap.
- On cap: sv <= v at the same edge, so sv is visible 1 cycle after the request cycle. A FIFO push of {timestamp at request cycle, v} is attempted.
- No cap: sv holds. Replaces the transparent latch with a registered capture.
- pop = rd_valid & rd_ready. Head advances on the edge. rd_data shows the next entry one cycle after the pop; first-word-fall-through, registered.
- Push when not full: accepted; level +1.
- Push when full with no pop in the same cycle: the new record is dropped, stored entries are untouched, overflow <= 1. sv still updates.
- Push when full with a pop in the same cycle: both are performed; level unchanged; no overflow.
- Push and pop together when not full: both performed; level unchanged.
- Pop when empty: ignored; rd_valid=0 there, so a pop cannot occur.
- Push into empty FIFO: rd_valid=1 and rd_data=new record on the next cycle. No bypass in the same cycle.
- overflow: sticky. clr_ovf=1 clears it at the edge. If a set event and clr_ovf occur in the same cycle, set wins (overflow=1).
- level is always equal to the number of stored entries, in the range 0..DEPTH. rd_valid = (level != 0).
- Read and write pointers use log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are distinguished by level, not by pointer equality.
- rd_data is undefined (not checked) while rd_valid=0.

Test Plan:
- Reset then idle 10 cycles -> sv=0, rd_valid=0, level=0, overflow=0; timestamp internal=10 (check via the next capture's stamp).
- WIDTH=8, CHANGE_ONLY=0, sample_ov pulse with v=0xA5 at cycle 3 after reset -> sv=0xA5 at cycle 4; rd_data={3,0xA5}; level=1; hold rd_ready=1 -> level=0 next cycle.
- DEPTH=4, five call_emu_pre pulses (v=1..5), rd_ready=0 -> level=4, overflow=1, entries read back 1,2,3,4, sv=5. Then clr_ovf -> overflow=0.
- Full FIFO, push and pop in the same cycle -> level stays 4, overflow stays 0, the new record is the last one read.
- CHANGE_ONLY=1, v held at 0x3C, six requests -> exactly one entry; change v to 0x3D with a request -> second entry; v=0 at the first request after reset -> captured (primed rule).
- Assert rst with level=3 and a pending request -> next cycle level=0, sv=0, rd_valid=0, no push. Also: TSW=4 run past 15 cycles -> stamp wraps to 0.

Source files
------------

// File: rtl/ixc_sample_fifo.sv
// Registered sample capture plus timestamped FIFO; sv and new records visible 1 cycle after the request.
// Host drains via rd_valid/rd_ready; a capture into a full FIFO without a same-cycle pop is dropped and flagged.
module ixc_sample_fifo #(
   parameter int WIDTH       = 1,
   parameter int DEPTH       = 4,
   parameter int TSW         = 16,
   parameter int CHANGE_ONLY = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             v,
   input  logic                         sample_ov,
   input  logic                         call_emu_pre,
   output logic [WIDTH-1:0]             sv,
   output logic                         rd_valid,
   input  logic                         rd_ready,
   output logic [TSW+WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         overflow,
   input  logic                         clr_ovf
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH + 1);
   localparam int RW = TSW + WIDTH;

   logic [RW-1:0]    mem_q [DEPTH];
   logic [RW-1:0]    mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [TSW-1:0]   ts_q, ts_d;
   logic [WIDTH-1:0] sv_q, sv_d;
   logic             ovf_q, ovf_d;
   logic             primed_q, primed_d;

   logic req, cap, pop, push, full;

   always_comb begin
      req  = sample_ov | call_emu_pre;
      cap  = req && ((CHANGE_ONLY == 0) || !primed_q || (v != sv_q));
      full = (level_q == LW'(DEPTH));
      pop  = (level_q != '0) && rd_ready;
      // A full FIFO still accepts a push when the head leaves on the same edge.
      push = cap && (!full || pop);

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ts_d     = ts_q + TSW'(1);
      sv_d     = sv_q;
      ovf_d    = ovf_q;
      primed_d = primed_q;

      if (cap) begin
         sv_d     = v;
         primed_d = 1'b1;
      end
      if (push) begin
         mem_d[wr_ptr_q] = {ts_q, v};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push) begin
         level_d = level_q - LW'(1);
      end

      if (cap && full && !pop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ts_q     <= '0;
         sv_q     <= '0;
         ovf_q    <= 1'b0;
         primed_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ts_q     <= ts_d;
         sv_q     <= sv_d;
         ovf_q    <= ovf_d;
         primed_q <= primed_d;
      end
   end

   // Storage needs no reset: level gates every read.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign sv       = sv_q;
   assign rd_valid = (level_q != '0);
   assign rd_data  = mem_q[rd_ptr_q];
   assign level    = level_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_ixc_sample_fifo.sv
// Bench for ixc_sample_fifo: a default-mode instance (WIDTH=8, DEPTH=4, TSW=16) and a change-only instance (DEPTH=2, TSW=4).
module tb_ixc_sample_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_ov, a_pre, a_rdy, a_clr;
   logic [7:0]  a_v, a_sv;
   logic        a_vld, a_ovf;
   logic [23:0] a_dat;
   logic [2:0]  a_lvl;

   logic        b_rst, b_ov, b_pre, b_rdy, b_clr;
   logic [7:0]  b_v, b_sv;
   logic        b_vld, b_ovf;
   logic [11:0] b_dat;
   logic [1:0]  b_lvl;

   ixc_sample_fifo #(.WIDTH(8), .DEPTH(4), .TSW(16), .CHANGE_ONLY(0)) u_a (
      .clk(clk), .rst(a_rst), .v(a_v), .sample_ov(a_ov), .call_emu_pre(a_pre),
      .sv(a_sv), .rd_valid(a_vld), .rd_ready(a_rdy), .rd_data(a_dat),
      .level(a_lvl), .overflow(a_ovf), .clr_ovf(a_clr));

   ixc_sample_fifo #(.WIDTH(8), .DEPTH(2), .TSW(4), .CHANGE_ONLY(1)) u_b (
      .clk(clk), .rst(b_rst), .v(b_v), .sample_ov(b_ov), .call_emu_pre(b_pre),
      .sv(b_sv), .rd_valid(b_vld), .rd_ready(b_rdy), .rd_data(b_dat),
      .level(b_lvl), .overflow(b_ovf), .clr_ovf(b_clr));

   typedef struct {
      logic       rst, ov, pre;
      logic [7:0] v;
      logic       rdy, clr;
      logic [7:0] e_sv;
      logic [2:0] e_lvl;
      logic       e_ovf;
   } vec_t;

   int n_chk  = 0;
   int n_pass = 0;

   logic [23:0] sb [$];
   logic [15:0] m_ts = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic vec_t mk(input logic rst, input logic ov, input logic pre, input logic [7:0] v,
                               input logic rdy, input logic clr, input logic [7:0] e_sv,
                               input logic [2:0] e_lvl, input logic e_ovf);
      vec_t t;
      t.rst = rst; t.ov = ov; t.pre = pre; t.v = v; t.rdy = rdy; t.clr = clr;
      t.e_sv = e_sv; t.e_lvl = e_lvl; t.e_ovf = e_ovf;
      return t;
   endfunction

   // One cycle on instance A: scoreboard pushes expected records, pops compare rd_data.
   task automatic a_step(input vec_t t, input string nm);
      logic        full, popd;
      logic [23:0] exp;
      @(negedge clk);
      a_rst = t.rst; a_ov = t.ov; a_pre = t.pre; a_v = t.v; a_rdy = t.rdy; a_clr = t.clr;
      #1;
      if (t.rst) begin
         sb.delete();
         m_ts = '0;
      end else begin
         full = (sb.size() == 4);
         popd = t.rdy && (sb.size() != 0);
         if (popd) begin
            exp = sb.pop_front();
            chk({nm, " rd_data"}, 32'(a_dat), 32'(exp));
         end
         if ((t.ov || t.pre) && (!full || popd)) sb.push_back({m_ts, t.v});
         m_ts++;
      end
      @(posedge clk);
      #1;
      chk({nm, " sv"}, 32'(a_sv), 32'(t.e_sv));
      chk({nm, " level"}, 32'(a_lvl), 32'(t.e_lvl));
      chk({nm, " overflow"}, 32'(a_ovf), 32'(t.e_ovf));
      chk({nm, " rd_valid"}, 32'(a_vld), 32'(t.e_lvl != 0));
   endtask

   task automatic b_step(input logic rst, input logic req, input logic [7:0] v, input logic rdy);
      @(negedge clk);
      b_rst = rst; b_pre = req; b_v = v; b_rdy = rdy;
      @(posedge clk);
      #1;
   endtask

   vec_t tbl [27];

   initial begin
      a_rst = 1'b1; a_ov = 1'b0; a_pre = 1'b0; a_v = '0; a_rdy = 1'b0; a_clr = 1'b0;
      b_rst = 1'b1; b_ov = 1'b0; b_pre = 1'b0; b_v = '0; b_rdy = 1'b0; b_clr = 1'b0;

      //             rst ov pre v      rdy clr  e_sv   lvl ovf
      tbl[0]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
      tbl[1]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
      tbl[2]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
      tbl[3]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
      tbl[4]  = mk(0, 1, 0, 8'hA5, 0, 0, 8'hA5, 1, 0);
      tbl[5]  = mk(0, 0, 0, 8'h00, 1, 0, 8'hA5, 0, 0);
      tbl[6]  = mk(0, 0, 0, 8'h00, 0, 0, 8'hA5, 0, 0);
      tbl[7]  = mk(0, 0, 1, 8'h01, 0, 0, 8'h01, 1, 0);
      tbl[8]  = mk(0, 0, 1, 8'h02, 0, 0, 8'h02, 2, 0);
      tbl[9]  = mk(0, 0, 1, 8'h03, 0, 0, 8'h03, 3, 0);
      tbl[10] = mk(0, 0, 1, 8'h04, 0, 0, 8'h04, 4, 0);
      tbl[11] = mk(0, 0, 1, 8'h05, 0, 0, 8'h05, 4, 1);
      tbl[12] = mk(0, 0, 0, 8'h00, 0, 1, 8'h05, 4, 0);
      tbl[13] = mk(0, 0, 1, 8'h06, 1, 0, 8'h06, 4, 0);
      tbl[14] = mk(0, 0, 0, 8'h00, 1, 0, 8'h06, 3, 0);
      tbl[15] = mk(0, 0, 0, 8'h00, 1, 0, 8'h06, 2, 0);
      tbl[16] = mk(0, 0, 0, 8'h00, 1, 0, 8'h06, 1, 0);
      tbl[17] = mk(0, 0, 0, 8'h00, 1, 0, 8'h06, 0, 0);
      tbl[18] = mk(0, 0, 1, 8'h07, 0, 0, 8'h07, 1, 0);
      tbl[19] = mk(0, 1, 0, 8'h08, 0, 0, 8'h08, 2, 0);
      tbl[20] = mk(0, 0, 1, 8'h09, 0, 0, 8'h09, 3, 0);
      tbl[21] = mk(0, 1, 1, 8'h0A, 0, 0, 8'h0A, 4, 0);
      tbl[22] = mk(0, 0, 1, 8'h0B, 0, 1, 8'h0B, 4, 1);
      tbl[23] = mk(0, 0, 0, 8'h00, 1, 0, 8'h0B, 3, 1);
      tbl[24] = mk(0, 0, 1, 8'h0C, 1, 0, 8'h0C, 3, 1);
      tbl[25] = mk(1, 0, 1, 8'h55, 1, 0, 8'h00, 0, 0);
      tbl[26] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);

      for (int i = 0; i < 27; i++) a_step(tbl[i], $sformatf("row%0d", i));

      // Reset, idle ten cycles, then capture: stamp must read 10.
      a_step(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0), "ts_rst");
      for (int i = 0; i < 10; i++) a_step(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0), $sformatf("idle%0d", i));
      a_step(mk(0, 1, 0, 8'h77, 0, 0, 8'h77, 1, 0), "ts_cap");
      chk("stamp10 rd_data", 32'(a_dat), 32'({16'd10, 8'h77}));
      a_step(mk(0, 0, 0, 8'h00, 1, 0, 8'h77, 0, 0), "ts_pop");
      chk("scoreboard empty", 32'(sb.size()), 32'd0);

      // Change-only instance with a 4-bit wrapping stamp.
      b_step(1, 0, 8'h00, 0);
      chk("b reset level", 32'(b_lvl), 32'd0);
      chk("b reset rd_valid", 32'(b_vld), 32'd0);
      b_step(0, 1, 8'h00, 0);
      chk("b primed first cap", 32'(b_lvl), 32'd1);
      for (int i = 0; i < 5; i++) b_step(0, 1, 8'h00, 0);
      chk("b dup suppressed level", 32'(b_lvl), 32'd1);
      chk("b dup sv", 32'(b_sv), 32'h00);
      chk("b head0", 32'(b_dat), 32'h000);
      b_step(0, 1, 8'h01, 0);
      chk("b change level", 32'(b_lvl), 32'd2);
      chk("b change sv", 32'(b_sv), 32'h01);
      b_step(0, 1, 8'h01, 0);
      chk("b repeat level", 32'(b_lvl), 32'd2);
      chk("b repeat ovf", 32'(b_ovf), 32'd0);
      b_step(0, 1, 8'h02, 0);
      chk("b full drop ovf", 32'(b_ovf), 32'd1);
      chk("b full drop sv", 32'(b_sv), 32'h02);
      chk("b full drop level", 32'(b_lvl), 32'd2);
      for (int i = 0; i < 6; i++) b_step(0, 0, 8'h00, 0);
      chk("b head before pop", 32'(b_dat), 32'h000);
      b_step(0, 0, 8'h00, 1);
      chk("b pop level", 32'(b_lvl), 32'd1);
      chk("b second entry", 32'(b_dat), 32'h601);
      b_step(0, 1, 8'h03, 1);
      chk("b push+pop level", 32'(b_lvl), 32'd1);
      chk("b wrapped stamp", 32'(b_dat), 32'h003);
      chk("b wrapped sv", 32'(b_sv), 32'h03);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
